id_stage: RTL and testbench

- Decode/operand-fetch stage that feeds the 8-bit ALU execute stage.
- Accepts 16-bit instructions from fetch and holds a 4-entry x 8-bit register file with a writeback port.
- Applies EX/WB forwarding and presents opcode, operands and destination register through a registered ID/EX pipeline boundary with valid/ready flow control.

---
 rtl/id_stage_pkg.sv | 36 +++
 rtl/id_regfile.sv | 33 +++
 rtl/id_stage.sv | 97 +++++++++
 tb/tb_id_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: opcode constants, instruction field positions and decode helpers shared by ID and EX
package id_stage_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SHL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] OP_LI   = 4'd6;
    localparam logic [3:0] OP_NOP  = 4'd7;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // ALU ops and LI produce an execute-stage op; NOP and the upper half do not
    function automatic logic produces_op(input logic [3:0] op);
        return op <= OP_LI;
    endfunction

    // The whole upper opcode half is reserved
    function automatic logic is_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: 4-entry register file, one write port, two read ports with same-cycle write-through
module id_regfile
    import id_stage_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] RF_RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [1:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [1:0]        ra1,
    input  logic [1:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] mem [4];

    // Write port: updates regardless of pipeline stall or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= RF_RST_VAL;
        end else if (wb_en) begin
            mem[wb_rd] <= wb_data;
        end
    end

    assign rd1 = (wb_en && wb_rd == ra1) ? wb_data : mem[ra1];
    assign rd2 = (wb_en && wb_rd == ra2) ? wb_data : mem[ra2];

endmodule

// File: rtl/id_stage.sv
// id_stage: decode/operand fetch with EX/WB forwarding and a registered valid/ready ID/EX boundary
module id_stage
    import id_stage_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] RF_RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [1:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_fwd_en,
    input  logic [1:0]        ex_fwd_rd,
    input  logic [DATA_W-1:0] ex_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [1:0]        out_rd,
    output logic              illegal_op
);

    logic [3:0]        op;
    logic [1:0]        rd;
    logic [1:0]        rs1;
    logic [1:0]        rs2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] nxt_a;
    logic [DATA_W-1:0] nxt_b;
    logic [3:0]        nxt_op;
    logic              accept;
    logic              load;

    assign op  = in_instr[OP_MSB:OP_LSB];
    assign rd  = in_instr[RD_MSB:RD_LSB];
    assign rs1 = in_instr[RS1_MSB:RS1_LSB];
    assign rs2 = in_instr[RS2_MSB:RS2_LSB];
    assign imm = DATA_W'(in_instr[IMM_MSB:IMM_LSB]);

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign load     = accept && produces_op(op);

    id_regfile #(
        .DATA_W     (DATA_W),
        .RF_RST_VAL (RF_RST_VAL)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .ra1     (rs1),
        .ra2     (rs2),
        .rd1     (rf_a),
        .rd2     (rf_b)
    );

    // Operand select: EX result beats the RF path, which already carries the WB write-through
    always_comb begin
        nxt_op = (op == OP_LI) ? ALU_ADD : op;
        nxt_a  = (op == OP_LI) ? imm
               : (ex_fwd_en && ex_fwd_rd == rs1) ? ex_fwd_data : rf_a;
        nxt_b  = (op == OP_LI) ? '0
               : (ex_fwd_en && ex_fwd_rd == rs2) ? ex_fwd_data : rf_b;
    end

    // ID/EX register: flush clears valid, accept reloads, a stall holds every field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_a      <= '0;
            out_b      <= '0;
            out_rd     <= '0;
            illegal_op <= 1'b0;
        end else begin
            out_valid  <= flush ? 1'b0 : accept ? produces_op(op) : out_valid && !out_ready;
            illegal_op <= accept && is_illegal(op);
            if (load) begin
                out_opcode <= nxt_op;
                out_a      <= nxt_a;
                out_b      <= nxt_b;
                out_rd     <= rd;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table-driven and sequence checks of id_stage against a bench-side expectation queue
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [1:0]  wb_rd = '0;
    logic [7:0]  wb_data = '0;
    logic        ex_fwd_en = 1'b0;
    logic [1:0]  ex_fwd_rd = '0;
    logic [7:0]  ex_fwd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_opcode;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [1:0]  out_rd;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       ev;
        logic [3:0] eop;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [1:0] erd;
        logic       eill;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [15:0] instr;
        logic        wbe;
        logic [1:0]  wbrd;
        logic [7:0]  wbd;
        logic        fe;
        logic [1:0]  frd;
        logic [7:0]  fd;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    vec_t vecs[13];

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_fwd_en   (ex_fwd_en),
        .ex_fwd_rd   (ex_fwd_rd),
        .ex_fwd_data (ex_fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 6'b0};
    endfunction

    function automatic logic [15:0] li(input logic [1:0] rd, input logic [7:0] imm);
        return {4'd6, rd, 2'b00, imm};
    endfunction

    function automatic exp_t ex(input logic v, input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [1:0] rd, input logic ill);
        exp_t e;
        e.ev = v; e.eop = op; e.ea = a; e.eb = b; e.erd = rd; e.eill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk("out_valid", {7'b0, out_valid}, {7'b0, e.ev});
        chk("illegal_op", {7'b0, illegal_op}, {7'b0, e.eill});
        if (e.ev) begin
            chk("out_opcode", {4'b0, out_opcode}, {4'b0, e.eop});
            chk("out_a", out_a, e.ea);
            chk("out_b", out_b, e.eb);
            chk("out_rd", {6'b0, out_rd}, {6'b0, e.erd});
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] instr, input logic wbe,
                         input logic [1:0] wbrd, input logic [7:0] wbd, input logic fe,
                         input logic [1:0] frd, input logic [7:0] fd);
        in_valid = iv; in_instr = instr; wb_en = wbe; wb_rd = wbrd; wb_data = wbd;
        ex_fwd_en = fe; ex_fwd_rd = frd; ex_fwd_data = fd;
    endtask

    task automatic step_check(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        check_out(q.pop_front());
    endtask

    initial begin
        exp_t held;
        vecs[0]  = '{1'b0, 16'h0000,             1'b1, 2'd1, 8'h12, 1'b0, 2'd0, 8'h00, ex(0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 16'h0000,             1'b1, 2'd2, 8'h34, 1'b0, 2'd0, 8'h00, ex(0, 0, 0, 0, 0, 0)};
        vecs[2]  = '{1'b1, mk(4'd0, 3, 1, 2),    1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ex(1, 0, 8'h12, 8'h34, 3, 0)};
        vecs[3]  = '{1'b1, li(2'd0, 8'hA5),      1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ex(1, 0, 8'hA5, 8'h00, 0, 0)};
        vecs[4]  = '{1'b1, mk(4'd1, 2, 1, 0),    1'b1, 2'd1, 8'h55, 1'b1, 2'd1, 8'h77, ex(1, 1, 8'h77, 8'h00, 2, 0)};
        vecs[5]  = '{1'b1, mk(4'd1, 2, 1, 1),    1'b1, 2'd1, 8'h99, 1'b0, 2'd0, 8'h00, ex(1, 1, 8'h99, 8'h99, 2, 0)};
        vecs[6]  = '{1'b1, mk(4'd5, 1, 1, 3),    1'b1, 2'd2, 8'h44, 1'b1, 2'd3, 8'h0F, ex(1, 5, 8'h99, 8'h0F, 1, 0)};
        vecs[7]  = '{1'b1, 16'hC000,             1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ex(0, 0, 0, 0, 0, 1)};
        vecs[8]  = '{1'b1, 16'h7000,             1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ex(0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{1'b1, mk(4'd4, 0, 2, 2),    1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ex(1, 4, 8'h44, 8'h44, 0, 0)};
        vecs[10] = '{1'b0, mk(4'd4, 0, 2, 2),    1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ex(0, 0, 0, 0, 0, 0)};
        vecs[11] = '{1'b1, mk(4'd3, 2, 0, 3),    1'b1, 2'd3, 8'hC3, 1'b0, 2'd0, 8'h00, ex(1, 3, 8'h00, 8'hC3, 2, 0)};
        vecs[12] = '{1'b1, mk(4'd2, 3, 3, 2),    1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, ex(1, 2, 8'hC3, 8'h44, 3, 0)};

        #12;
        check_out(ex(1'b0, 0, 0, 0, 0, 1'b0));
        chk("rst_opcode", {4'b0, out_opcode}, 8'h00);
        chk("rst_a", out_a, 8'h00);
        chk("rst_b", out_b, 8'h00);
        chk("rst_rd", {6'b0, out_rd}, 8'h00);
        chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].instr, vecs[i].wbe, vecs[i].wbrd, vecs[i].wbd,
                  vecs[i].fe, vecs[i].frd, vecs[i].fd);
            step_check(vecs[i].e);
            chk("in_ready_flow", {7'b0, in_ready}, 8'h01);
        end

        // Stall for three cycles with a pending instruction and a concurrent RF write
        drive(1, mk(4'd0, 3, 1, 2), 0, 0, 0, 0, 0, 0);
        held = ex(1, 0, 8'h99, 8'h44, 3, 0);
        step_check(held);
        out_ready = 1'b0;
        drive(1, li(2'd1, 8'h3C), 1, 2'd1, 8'h11, 0, 0, 0);
        #1;
        chk("stall_in_ready", {7'b0, in_ready}, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step_check(held);
            chk("stall_in_ready", {7'b0, in_ready}, 8'h00);
        end
        wb_en = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {7'b0, in_ready}, 8'h01);
        step_check(ex(1, 0, 8'h3C, 8'h00, 1, 0));
        drive(0, 16'h0000, 0, 0, 0, 0, 0, 0);
        step_check(ex(0, 0, 0, 0, 0, 0));

        // Flush drops the incoming beat, including an illegal one
        drive(1, mk(4'd0, 0, 1, 1), 0, 0, 0, 0, 0, 0);
        step_check(ex(1, 0, 8'h11, 8'h11, 0, 0));
        flush = 1'b1;
        drive(1, li(2'd2, 8'hEE), 0, 0, 0, 0, 0, 0);
        chk("flush_in_ready", {7'b0, in_ready}, 8'h01);
        step_check(ex(0, 0, 0, 0, 0, 0));
        drive(1, 16'hF000, 0, 0, 0, 0, 0, 0);
        step_check(ex(0, 0, 0, 0, 0, 0));
        flush = 1'b0;
        drive(0, 16'h0000, 0, 0, 0, 0, 0, 0);
        step_check(ex(0, 0, 0, 0, 0, 0));

        // Asynchronous reset while stalled clears outputs and the register file
        drive(1, mk(4'd1, 1, 2, 3), 0, 0, 0, 0, 0, 0);
        step_check(ex(1, 1, 8'h44, 8'hC3, 1, 0));
        out_ready = 1'b0;
        drive(1, li(2'd0, 8'h01), 0, 0, 0, 0, 0, 0);
        step_check(ex(1, 1, 8'h44, 8'hC3, 1, 0));
        rst = 1'b1;
        #1;
        chk("arst_valid", {7'b0, out_valid}, 8'h00);
        chk("arst_opcode", {4'b0, out_opcode}, 8'h00);
        chk("arst_a", out_a, 8'h00);
        chk("arst_b", out_b, 8'h00);
        chk("arst_rd", {6'b0, out_rd}, 8'h00);
        chk("arst_in_ready", {7'b0, in_ready}, 8'h01);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(0, 16'h0000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, mk(4'd0, 2, 1, 3), 0, 0, 0, 0, 0, 0);
        step_check(ex(1, 0, 8'h00, 8'h00, 2, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
